// File: rtl/fxyz_sweep_ctrl.sv
// Sweep controller for the (x.y)'.z function block: steps {x,y,z} through vectors 0..7,
// captures s into a truth table and grades it against the expected table latched at start.
module fxyz_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] exp,
  input  logic       s,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] truth_table,
  output logic [3:0] mismatches,
  output logic [2:0] first_fail,
  output logic       fail_valid
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] xyz_q, xyz_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [7:0] exp_l_q, exp_l_d;
  logic [7:0] table_q, table_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       fv_q, fv_d;
  logic [3:0] mism_q, mism_d;
  logic [2:0] ff_q, ff_d;

  logic [7:0] diff;
  logic [3:0] pop;
  logic [2:0] first;
  logic       found;

  // Grading only matters on the vector-7 sample edge, where the final table is
  // the captured bits 0..6 plus the live s.
  always_comb begin
    diff  = {s, table_q[6:0]} ^ exp_l_q;
    pop   = '0;
    first = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      pop = pop + 4'(diff[i]);
      if (diff[i] && !found) begin
        first = 3'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    xyz_d   = xyz_q;
    wcnt_d  = wcnt_q;
    exp_l_d = exp_l_q;
    table_d = table_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fv_d    = fv_q;
    mism_d  = mism_q;
    ff_d    = ff_q;
    case (state_q)
      IDLE, DONE: begin
        if (start && !abort) begin
          state_d = RUN;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fv_d    = 1'b0;
          table_d = '0;
          mism_d  = '0;
          ff_d    = '0;
          exp_l_d = exp;
          idx_d   = '0;
          wcnt_d  = '0;
          xyz_d   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          table_d = '0;
          xyz_d   = '0;
          idx_d   = '0;
          wcnt_d  = '0;
        end else if (wcnt_q != SETTLE_C) begin
          wcnt_d = wcnt_q + 4'd1;
        end else begin
          table_d[idx_q] = s;
          wcnt_d         = '0;
          if (idx_q != 3'd7) begin
            idx_d = idx_q + 3'd1;
            xyz_d = idx_q + 3'd1;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            xyz_d   = '0;
            idx_d   = '0;
            pass_d  = (pop == 4'd0);
            fv_d    = (pop != 4'd0);
            mism_d  = pop;
            ff_d    = first;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      xyz_q   <= '0;
      wcnt_q  <= '0;
      exp_l_q <= '0;
      table_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fv_q    <= 1'b0;
      mism_q  <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      xyz_q   <= xyz_d;
      wcnt_q  <= wcnt_d;
      exp_l_q <= exp_l_d;
      table_q <= table_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fv_q    <= fv_d;
      mism_q  <= mism_d;
      ff_q    <= ff_d;
    end
  end

  assign x           = xyz_q[2];
  assign y           = xyz_q[1];
  assign z           = xyz_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign truth_table = table_q;
  assign mismatches  = mism_q;
  assign first_fail  = ff_q;
  assign fail_valid  = fv_q;

endmodule

// File: tb/tb_fxyz_sweep_ctrl.sv
// Bench for fxyz_sweep_ctrl: three instances (SETTLE 1, 0, 3) each beside a table-lookup function block.
module tb_fxyz_sweep_ctrl;

  localparam int NDUT = 3;
  localparam int ST [NDUT] = '{1, 0, 3};

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] exp_i;
  logic [7:0] fn_tab;
  logic       start_v [NDUT];
  logic       abort_v [NDUT];

  wire       s_w    [NDUT];
  wire       x_w    [NDUT];
  wire       y_w    [NDUT];
  wire       z_w    [NDUT];
  wire       busy_w [NDUT];
  wire       done_w [NDUT];
  wire       pass_w [NDUT];
  wire       fv_w   [NDUT];
  wire [7:0] tt_w   [NDUT];
  wire [3:0] mm_w   [NDUT];
  wire [2:0] ff_w   [NDUT];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign s_w[g] = fn_tab[{x_w[g], y_w[g], z_w[g]}];
    fxyz_sweep_ctrl #(.SETTLE(ST[g])) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start_v[g]),
      .abort      (abort_v[g]),
      .exp        (exp_i),
      .s          (s_w[g]),
      .x          (x_w[g]),
      .y          (y_w[g]),
      .z          (z_w[g]),
      .busy       (busy_w[g]),
      .done       (done_w[g]),
      .pass       (pass_w[g]),
      .truth_table(tt_w[g]),
      .mismatches (mm_w[g]),
      .first_fail (ff_w[g]),
      .fail_valid (fv_w[g])
    );
  end

  typedef struct {
    int         d;
    logic [7:0] fn;
    logic [7:0] e;
    logic [7:0] tt;
    int         mm;
    int         ff;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int d, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, d, act, req, $time);
    end
  endtask

  function automatic int xyz_of(input int d);
    return int'({x_w[d], y_w[d], z_w[d]});
  endfunction

  task automatic check_idle(input string nm, input int d);
    chk({nm, "_busy"}, d, busy_w[d], 0);
    chk({nm, "_done"}, d, done_w[d], 0);
    chk({nm, "_table"}, d, tt_w[d], 0);
    chk({nm, "_xyz"}, d, xyz_of(d), 0);
    chk({nm, "_pass"}, d, pass_w[d], 0);
    chk({nm, "_mism"}, d, mm_w[d], 0);
    chk({nm, "_ffail"}, d, ff_w[d], 0);
    chk({nm, "_fvalid"}, d, fv_w[d], 0);
  endtask

  // Reference: vector i is driven while s is sampled, so the captured table is the
  // function's own truth table; grading is a bitwise compare against exp.
  function automatic void model(input logic [7:0] fn, input logic [7:0] e,
                                output logic [7:0] tt, output int mm, output int ff);
    tt = fn;
    mm = 0;
    ff = 0;
    for (int i = 7; i >= 0; i--) begin
      if (fn[i] != e[i]) begin
        mm++;
        ff = i;
      end
    end
  endfunction

  task automatic run_sweep(input int d, input logic [7:0] e, input int restart_at,
                           input int abort_at, input int reset_at,
                           input logic [7:0] r_tt, input int r_mm, input int r_ff);
    int n;
    n = 8 * (ST[d] + 1);
    exp_i = e;
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
    for (int c = 0; c < n; c++) begin
      chk("run_busy", d, busy_w[d], 1);
      chk("run_done", d, done_w[d], 0);
      chk("run_xyz", d, xyz_of(d), c / (ST[d] + 1));
      if (c == 0) begin
        chk("clr_table", d, tt_w[d], 0);
        chk("clr_pass", d, pass_w[d], 0);
        chk("clr_mism", d, mm_w[d], 0);
        chk("clr_ffail", d, ff_w[d], 0);
        chk("clr_fvalid", d, fv_w[d], 0);
      end
      exp_i = 8'($urandom);
      if (c == restart_at) start_v[d] = 1'b1;
      if (c == abort_at) abort_v[d] = 1'b1;
      if (c == reset_at) reset = 1'b1;
      tick();
      start_v[d] = 1'b0;
      if (c == abort_at) begin
        abort_v[d] = 1'b0;
        check_idle("abort", d);
        return;
      end
      if (c == reset_at) begin
        reset = 1'b0;
        for (int k = 0; k < NDUT; k++) check_idle("midreset", k);
        return;
      end
    end
    chk("end_done", d, done_w[d], 1);
    chk("end_busy", d, busy_w[d], 0);
    chk("end_xyz", d, xyz_of(d), 0);
    chk("end_table", d, tt_w[d], r_tt);
    chk("end_pass", d, pass_w[d], (r_mm == 0) ? 1 : 0);
    chk("end_mism", d, mm_w[d], r_mm);
    chk("end_ffail", d, ff_w[d], r_ff);
    chk("end_fvalid", d, fv_w[d], (r_mm != 0) ? 1 : 0);
    tick();
    chk("hold_done", d, done_w[d], 1);
    chk("hold_table", d, tt_w[d], r_tt);
  endtask

  initial begin
    logic [7:0] m_tt;
    int         m_mm;
    int         m_ff;
    int         d;
    logic [7:0] e;

    vecs[0] = '{0, 8'h2A, 8'h2A, 8'h2A, 0, 0};
    vecs[1] = '{0, 8'hAA, 8'h2A, 8'hAA, 1, 7};
    vecs[2] = '{1, 8'h00, 8'h2A, 8'h00, 3, 1};
    vecs[3] = '{2, 8'h2A, 8'h2A, 8'h2A, 0, 0};
    vecs[4] = '{1, 8'hFF, 8'h00, 8'hFF, 8, 0};
    vecs[5] = '{2, 8'h81, 8'h01, 8'h81, 1, 7};

    reset  = 1'b1;
    exp_i  = 8'h00;
    fn_tab = 8'h2A;
    for (int k = 0; k < NDUT; k++) begin
      start_v[k] = 1'b0;
      abort_v[k] = 1'b0;
    end
    tick();
    tick();
    for (int k = 0; k < NDUT; k++) check_idle("reset", k);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      fn_tab = vecs[i].fn;
      run_sweep(vecs[i].d, vecs[i].e, -1, -1, -1, vecs[i].tt, vecs[i].mm, vecs[i].ff);
    end

    // start during RUN is ignored, then a restart from DONE repeats the result
    fn_tab = 8'h2A;
    run_sweep(0, 8'h2A, 2, -1, -1, 8'h2A, 0, 0);
    run_sweep(0, 8'h2A, -1, -1, -1, 8'h2A, 0, 0);

    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    chk("done_sa_done", 0, done_w[0], 1);
    chk("done_sa_busy", 0, busy_w[0], 0);
    chk("done_sa_table", 0, tt_w[0], 8'h2A);

    run_sweep(0, 8'h2A, -1, -1, 8, 8'h00, 0, 0);

    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    tick();
    check_idle("idle_sa", 0);

    run_sweep(0, 8'h2A, -1, 4, -1, 8'h00, 0, 0);
    tick();
    check_idle("post_abort", 0);
    run_sweep(0, 8'h2A, -1, -1, -1, 8'h2A, 0, 0);

    for (int it = 0; it < 24; it++) begin
      d      = int'($urandom_range(0, NDUT - 1));
      fn_tab = 8'($urandom);
      e      = (it % 4 == 0) ? fn_tab : 8'($urandom);
      model(fn_tab, e, m_tt, m_mm, m_ff);
      run_sweep(d, e, (it % 3 == 0) ? int'($urandom_range(1, 6)) : -1, -1, -1, m_tt, m_mm, m_ff);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
